// File: rtl/key_press_ctrl_if.sv
// key_press_ctrl_if: raw push-button inputs, lock, and per-key debounced
// level and event pulses between the board buttons and game_core.
interface key_press_ctrl_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_n;
  logic              lock;
  logic [N_KEYS-1:0] held;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] short_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;
  modport master (
    output key_n, lock,
    input  held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
  );
  modport slave (
    input  key_n, lock,
    output held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_press_ctrl.sv
// key_press_ctrl: synchronizes and debounces active-low keys, then emits
// press/release/short/long/auto-repeat pulses per key, maskable by lock.
module key_press_ctrl #(
  parameter int N_KEYS       = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input logic              clk,
  input logic              reset_n,
  key_press_ctrl_if.slave  kp
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam int REP_W  = $clog2(REPEAT_CYC + 1);
  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [1:0]        sync_q, sync_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              held_q, held_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [4:0]        pulse_q, pulse_d;
    logic [4:0]        ev;
    logic              s, flip, rise, fall, long_hit, rep_hit;
    // ev / pulse bit order: {repeat, long, short, release, press}
    always_comb begin
      sync_d     = {sync_q[0], ~kp.key_n[k]};
      s          = sync_q[1];
      flip       = (s != held_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1));
      db_cnt_d   = (s == held_q || flip) ? '0
                 : db_cnt_q + DB_W'(db_cnt_q != DB_W'(DEBOUNCE_CYC));
      held_d     = held_q ^ flip;
      rise       = flip & ~held_q;
      fall       = flip & held_q;
      long_hit   = hold_cnt_q == HOLD_W'(LONG_CYC - 1);
      rep_hit    = rep_cnt_q == REP_W'(REPEAT_CYC - 1);
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      ev         = '0;
      if (state_q == IDLE) begin
        if (rise) begin
          state_d    = PRESS;
          hold_cnt_d = '0;
          ev[0]      = 1'b1;
        end
      end else if (fall) begin
        // a release wins over a long or repeat due on the same edge
        state_d = IDLE;
        ev[1]   = 1'b1;
        ev[2]   = state_q == PRESS;
      end else if (state_q == PRESS) begin
        if (long_hit) begin
          state_d   = LONG;
          rep_cnt_d = '0;
          ev[3]     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(hold_cnt_q != HOLD_W'(LONG_CYC));
        end
      end else begin
        ev[4]     = rep_hit;
        rep_cnt_d = rep_hit ? '0 : rep_cnt_q + REP_W'(1);
      end
      pulse_d = kp.lock ? '0 : ev;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        held_q     <= 1'b0;
        state_q    <= IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        pulse_q    <= '0;
      end else begin
        sync_q     <= sync_d;
        db_cnt_q   <= db_cnt_d;
        held_q     <= held_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        pulse_q    <= pulse_d;
      end
    end
    assign kp.held[k]          = held_q;
    assign kp.press_pulse[k]   = pulse_q[0];
    assign kp.release_pulse[k] = pulse_q[1];
    assign kp.short_pulse[k]   = pulse_q[2];
    assign kp.long_pulse[k]    = pulse_q[3];
    assign kp.repeat_pulse[k]  = pulse_q[4];
  end
endmodule
